// File: rtl/matrix_win_pkg.sv
// Shared types and helpers for the 3x3 window frame sequencer.
// State encoding and a constant-safe ceil(log2) for port widths.
package matrix_win_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mwc_xy_counter.sv
// Pixel column/line counter for the window sequencer.
// Clear has priority over accept; x wraps at the last column.
module mwc_xy_counter
  import matrix_win_pkg::*;
#(
  parameter int W  = 1920,
  parameter int H  = 1080,
  parameter int XW = clog2(W + 1),
  parameter int YW = clog2(H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          wrap,
  output logic          last_line
);

  assign wrap      = (x == XW'(W - 1));
  assign last_line = (y == YW'(H - 1));

  // advance position on each accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (acc) begin
      if (wrap) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_win_ctrl.sv
// Frame sequencer for the two-line-FIFO 3x3 window generator.
// Optional line-length check: define MATRIX_WIN_LEN_CHECK_EN.
module matrix_win_ctrl
  import matrix_win_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int BORDER_LAT = 2
) (
  input  logic                             video_clk,
  input  logic                             rst_n,
  input  logic                             video_vs,
  input  logic                             video_de,
  output logic                             lb_fifo_rst,
  output logic                             lb_wr_en,
  output logic                             lb_rd_en,
  output logic                             gen_de,
  output logic [clog2(IMG_WIDTH+1)-1:0]    x_cnt,
  output logic [clog2(IMG_HEIGHT+1)-1:0]   y_cnt,
  output logic                             win_border,
  output logic                             frame_done,
  output logic                             busy,
  output logic                             err_len
);

  localparam int XW = clog2(IMG_WIDTH + 1);
  localparam int YW = clog2(IMG_HEIGHT + 1);

  state_t                state;
  logic                  vs_d;
  logic                  vs_rise;
  logic                  acc;
  logic                  wrap;
  logic                  last_line;
  logic                  flush_end;
  logic                  edge_hit;
  logic [BORDER_LAT-1:0] bsr;

  assign vs_rise   = video_vs & ~vs_d;
  assign gen_de    = (state == FLUSH);
  assign busy      = (state != IDLE);
  assign flush_end = gen_de & wrap;

  // pixel accept source depends on the phase
  always_comb begin
    acc = 1'b0;
    unique case (state)
      IDLE:        acc = 1'b0;
      PRIME, RUN:  acc = video_de;
      FLUSH:       acc = gen_de;
    endcase
  end

  mwc_xy_counter #(
    .W  (IMG_WIDTH),
    .H  (IMG_HEIGHT),
    .XW (XW),
    .YW (YW)
  ) u_xy (
    .clk       (video_clk),
    .rst_n     (rst_n),
    .acc       (acc),
    .clear     (vs_rise | flush_end),
    .x         (x_cnt),
    .y         (y_cnt),
    .wrap      (wrap),
    .last_line (last_line)
  );

  // line FIFO enables, zero latency; a restarting pixel is dropped
  always_comb begin
    lb_wr_en = 1'b0;
    lb_rd_en = 1'b0;
    if (!vs_rise && !err_len) begin
      unique case (state)
        IDLE: ;
        PRIME: lb_wr_en = video_de;
        RUN: begin
          lb_wr_en = video_de & (y_cnt < YW'(IMG_HEIGHT - 1));
          lb_rd_en = video_de;
        end
        FLUSH: lb_rd_en = gen_de;
      endcase
    end
  end

  // frame sequencing, restart pulse and completion pulse
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vs_d        <= 1'b0;
      lb_fifo_rst <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      vs_d        <= video_vs;
      lb_fifo_rst <= vs_rise;
      frame_done  <= 1'b0;
      if (vs_rise) begin
        state <= PRIME;
      end else begin
        unique case (state)
          IDLE:  state <= IDLE;
          PRIME: if (acc & wrap) state <= RUN;
          RUN:   if (acc & wrap & last_line) state <= FLUSH;
          FLUSH: if (flush_end) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        endcase
      end
    end
  end

  // flush line sits at y = IMG_HEIGHT, so it is always border
  assign edge_hit = acc & ((x_cnt == '0) | wrap | (y_cnt == '0) |
                           (y_cnt >= YW'(IMG_HEIGHT - 1)));

  // align border flag with the window datapath output
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      bsr <= '0;
    end else begin
      bsr[0] <= edge_hit;
      for (int i = 1; i < BORDER_LAT; i++) bsr[i] <= bsr[i-1];
    end
  end

  assign win_border = bsr[BORDER_LAT-1];

`ifdef MATRIX_WIN_LEN_CHECK_EN
  localparam int RW = clog2(IMG_WIDTH + 2);

  logic [RW-1:0] run_cnt;
  logic          de_d;
  logic          run_bad;

  assign run_bad = de_d & ~video_de &
                   ((state == PRIME) | (state == RUN)) &
                   (run_cnt != RW'(IMG_WIDTH));

  // measure each DE run; a run cut by a restart is discarded
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      de_d    <= 1'b0;
      err_len <= 1'b0;
    end else if (vs_rise) begin
      run_cnt <= '0;
      de_d    <= 1'b0;
      err_len <= 1'b0;
    end else begin
      de_d <= video_de;
      if (video_de) begin
        if (run_cnt != RW'(IMG_WIDTH + 1)) run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end
      if (run_bad) err_len <= 1'b1;
    end
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// Self-checking bench for matrix_win_ctrl, W=8 H=4 BORDER_LAT=2.
// Table-driven frame start plus hand sequences for corner cases.
module tb_matrix_win_ctrl;

  logic       video_clk;
  logic       rst_n;
  logic       video_vs;
  logic       video_de;
  logic       lb_fifo_rst;
  logic       lb_wr_en;
  logic       lb_rd_en;
  logic       gen_de;
  logic [3:0] x_cnt;
  logic [2:0] y_cnt;
  logic       win_border;
  logic       frame_done;
  logic       busy;
  logic       err_len;

  matrix_win_ctrl #(
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (4),
    .BORDER_LAT (2)
  ) dut (
    .video_clk   (video_clk),
    .rst_n       (rst_n),
    .video_vs    (video_vs),
    .video_de    (video_de),
    .lb_fifo_rst (lb_fifo_rst),
    .lb_wr_en    (lb_wr_en),
    .lb_rd_en    (lb_rd_en),
    .gen_de      (gen_de),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .win_border  (win_border),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_len     (err_len)
  );

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  typedef struct {
    bit vs;
    bit de;
    bit eb;
    bit wr;
    bit rd;
    bit frst;
    bit bsy;
    int x;
    int y;
  } vec_t;

  vec_t tbl [11];

  int n_chk = 0;
  int n_err = 0;
  int n_wr, n_rd, n_rst, n_done, n_gen;
  int gen_run, gen_max, y_max;
  int ncyc;
  bit blog [512];
  bit ebl  [512];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_acc();
    n_wr = 0; n_rd = 0; n_rst = 0; n_done = 0; n_gen = 0;
    gen_run = 0; gen_max = 0; y_max = 0; ncyc = 0;
  endtask

  task automatic cyc(input bit vs, input bit de, input bit eb);
    @(posedge video_clk);
    #1;
    video_vs = vs;
    video_de = de;
    @(negedge video_clk);
    n_wr   += int'(lb_wr_en);
    n_rd   += int'(lb_rd_en);
    n_rst  += int'(lb_fifo_rst);
    n_done += int'(frame_done);
    n_gen  += int'(gen_de);
    if (gen_de) begin
      gen_run++;
      if (gen_run > gen_max) gen_max = gen_run;
    end else begin
      gen_run = 0;
    end
    if (int'(y_cnt) > y_max) y_max = int'(y_cnt);
    if (ncyc < 512) begin
      blog[ncyc] = win_border;
      ebl[ncyc]  = eb;
      ncyc++;
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int l, input int n);
    for (int x = 0; x < n; x++)
      cyc(1'b0, 1'b1, (l == 0 || l >= 3 || x == 0 || x == 7));
  endtask

  task automatic flush(input bit de);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, de, 1'b1);
      chk($sformatf("flush%0d_gen", i), gen_de, 1);
      chk($sformatf("flush%0d_wr", i), lb_wr_en, 0);
      chk($sformatf("flush%0d_rd", i), lb_rd_en, 1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_pulse", frame_done, 1);
    chk("done_gen", gen_de, 0);
    chk("done_busy", busy, 0);
    chk("done_x", x_cnt, 0);
    chk("done_y", y_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_clear", frame_done, 0);
  endtask

  task automatic chk_border(input string tag);
    for (int i = 0; i + 2 < ncyc; i++)
      chk($sformatf("%s_%0d", tag, i), blog[i+2], ebl[i]);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_wr"}, n_wr, 24);
    chk({tag, "_rd"}, n_rd, 32);
    chk({tag, "_gen"}, n_gen, 8);
    chk({tag, "_genrun"}, gen_max, 8);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_ymax"}, y_max, 4);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    for (int i = 2; i < 10; i++)
      tbl[i] = '{0, 1, 1, 1, 0, 0, 1, i - 2, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};

    rst_n    = 1'b0;
    video_vs = 1'b0;
    video_de = 1'b0;
    repeat (3) @(posedge video_clk);
    #1 rst_n = 1'b1;
    clr_acc();
    gap(2);

    // reset in the middle of a frame
    cyc(1'b1, 1'b0, 1'b0);
    line(0, 3);
    chk("pre_rst_busy", busy, 1);
    @(posedge video_clk);
    #1;
    rst_n    = 1'b0;
    video_vs = 1'b0;
    video_de = 1'b1;
    @(negedge video_clk);
    chk("rst_fiforst", lb_fifo_rst, 0);
    chk("rst_wr", lb_wr_en, 0);
    chk("rst_rd", lb_rd_en, 0);
    chk("rst_gen", gen_de, 0);
    chk("rst_x", x_cnt, 0);
    chk("rst_y", y_cnt, 0);
    chk("rst_border", win_border, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_len, 0);
    repeat (3) @(posedge video_clk);
    #1 rst_n = 1'b1;
    clr_acc();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("idle_wr", n_wr, 0);
    chk("idle_rd", n_rd, 0);
    chk("idle_gen", n_gen, 0);
    chk("idle_busy", busy, 0);
    chk("idle_x", x_cnt, 0);
    gap(2);

    // frame 1: table-driven start, then lines 1..3 and flush
    clr_acc();
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].vs, tbl[i].de, tbl[i].eb);
      chk($sformatf("tbl%0d_wr", i), lb_wr_en, tbl[i].wr);
      chk($sformatf("tbl%0d_rd", i), lb_rd_en, tbl[i].rd);
      chk($sformatf("tbl%0d_frst", i), lb_fifo_rst, tbl[i].frst);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_x", i), x_cnt, tbl[i].x);
      chk($sformatf("tbl%0d_y", i), y_cnt, tbl[i].y);
    end
    gap(3);
    line(1, 8);
    gap(4);
    line(2, 8);
    gap(4);
    line(3, 8);
    flush(1'b0);
    chk("f1_fiforst", n_rst, 1);
    chk_frame("f1");
    chk_border("f1_border");
    chk("f1_err", err_len, 0);

    // frame 2: restart in the middle of line 2
    clr_acc();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    line(0, 8);
    gap(4);
    line(1, 8);
    gap(4);
    line(2, 5);
    cyc(1'b1, 1'b1, 1'b0);
    chk("rs_x_before", x_cnt, 5);
    chk("rs_y_before", y_cnt, 2);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rs_fiforst", lb_fifo_rst, 1);
    chk("rs_x", x_cnt, 0);
    chk("rs_y", y_cnt, 0);
    chk("rs_busy", busy, 1);
    chk("rs_no_done", n_done, 0);
    chk("rs_fiforst_cnt", n_rst, 2);

    // frame 3: continues from PRIME, DE held high during flush
    clr_acc();
    line(0, 8);
    chk("f3_fiforst_off", lb_fifo_rst, 0);
    gap(4);
    line(1, 8);
    gap(4);
    line(2, 8);
    gap(4);
    line(3, 8);
    flush(1'b1);
    chk_frame("f3");
    chk_border("f3_border");

`ifdef MATRIX_WIN_LEN_CHECK_EN
    // short line 1 sets the sticky length error
    clr_acc();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    line(0, 8);
    gap(4);
    line(1, 7);
    cyc(1'b0, 1'b0, 1'b0);
    chk("len_err_pre", err_len, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("len_err_set", err_len, 1);
    chk("len_err_wr", lb_wr_en, 0);
    chk("len_err_rd", lb_rd_en, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("len_err_hold", err_len, 1);
    chk("len_err_rd2", lb_rd_en, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("len_err_clr", err_len, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_win_ctrl.md
Name: matrix_win_ctrl

Overview:
- Frame sequencer for the 3x3 window generator's two-line-FIFO buffer.
- Tracks pixel position and drives the line-FIFO write, read and reset controls.
- After the last input line it generates a flush line (internal DE), so the final window row is emitted without waiting for the next frame.
- Sits between the video timing source and the window/line-buffer datapath, in the single video_clk domain.

Parameters:
- IMG_WIDTH, 1920: active pixels per line (≥3).
- IMG_HEIGHT, 1080: active lines per frame (≥3).
- BORDER_LAT, 2: cycles of delay applied to win_border so it aligns with window output (≥1).

Ports:
- video_clk  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active-low
- video_vs  in  1  frame sync, active-high; the rising edge starts a frame
- video_de  in  1  input pixel valid
- lb_fifo_rst  out  1  one-cycle synchronous reset pulse to both line FIFOs
- lb_wr_en  out  1  write enable for line FIFO 1
- lb_rd_en  out  1  read enable for both line FIFOs
- gen_de  out  1  internal DE during flush; the datapath ORs it with video_de
- x_cnt  out  XW  column of the current accepted pixel
- y_cnt  out  YW  line of the current accepted pixel
- win_border  out  1  window centre lies on an image edge, delayed BORDER_LAT
- frame_done  out  1  one-cycle pulse when flush completes
- busy  out  1  state ≠ IDLE
- err_len  out  1  sticky line-length error (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; vs edge register 0.
- vs_rise = video_vs & ~vs_d (vs_d registered).
- Any state, on vs_rise:
  - go to PRIME, clear x/y;
  - lb_fifo_rst = 1 on the next cycle only;
  - abort any flush with no frame_done.
- lb_wr_en and lb_rd_en are combinational from state and video_de (zero latency, same cycle as the data).
- Pixel accept: acc = video_de in PRIME/RUN, gen_de in FLUSH. On acc, x increments. At x == IMG_WIDTH-1, x wraps to 0 and y increments.
- Counters hold when acc = 0.
- IDLE:
  - all enables 0;
  - video_de ignored;
  - waits for vs_rise.
- PRIME (line 0):
  - lb_wr_en = video_de; lb_rd_en = 0;
  - at end of line 0, go to RUN with y = 1.
- RUN:
  - lb_wr_en = video_de & (y < IMG_HEIGHT-1);
  - lb_rd_en = video_de;
  - at end of line IMG_HEIGHT-1, go to FLUSH with x = 0.
- FLUSH:
  - gen_de = 1 for exactly IMG_WIDTH consecutive cycles;
  - lb_rd_en = gen_de; lb_wr_en = 0;
  - video_de is ignored;
  - on the final flush cycle, frame_done pulses on the next cycle, then go to IDLE with x = y = 0.
- win_border:
  - edge = acc & (x == 0 | x == IMG_WIDTH-1 | y == 0 | y ≥ IMG_HEIGHT-1);
  - the flush line is counted as y = IMG_HEIGHT and is always border;
  - edge passes through a BORDER_LAT-stage shift register.
- Widths: XW = clog2(IMG_WIDTH+1), YW = clog2(IMG_HEIGHT+1). Counters never exceed IMG_WIDTH-1 or IMG_HEIGHT.
- vs_rise and end-of-line in the same cycle: vs_rise wins (restart); the pixel is dropped.

Optional Feature:
- Macro MATRIX_WIN_LEN_CHECK_EN.
- When defined:
  - the block counts each video_de run;
  - a falling edge of DE with run ≠ IMG_WIDTH in PRIME or RUN sets err_len;
  - err_len is cleared only by vs_rise or reset;
  - while err_len = 1, lb_wr_en and lb_rd_en are forced 0 until the next vs_rise.
- When undefined: err_len is tied to 0 and no run counter is built.

Decomposition:
- Package matrix_win_pkg holds:
  - the state encoding (IDLE, PRIME, RUN, FLUSH);
  - the clog2 width function.
- One sub-module, mwc_xy_counter, holds the x/y counter with accept, wrap and clear inputs, and wrap/last-line outputs.
- The FSM, enables and border pipeline stay in the top level.

Test Plan (W=8, H=4, BORDER_LAT=2):
1. Reset mid-frame (rst_n low 3 cycles) → all outputs 0; busy 0; no enables until the next vs_rise.
2. vs_rise, then 4 lines of 8 DE cycles with 4-cycle gaps:
   - lb_fifo_rst is high one cycle;
   - lb_wr_en has 24 high cycles (lines 0–2);
   - lb_rd_en has 24 high cycles (lines 1–3), then 8 flush cycles;
   - gen_de is high for 8 consecutive cycles;
   - frame_done pulses once; y_cnt reaches 4.
3. win_border sequence on line 1 → 1,0,0,0,0,0,0,1, delayed 2 cycles; lines 0 and 3 and the flush line are all 1.
4. vs_rise during line 2 (x=5) → restart in PRIME, lb_fifo_rst pulse, x=y=0, no frame_done.
5. video_de high during FLUSH → ignored; gen_de is still exactly 8 cycles; lb_wr_en stays 0.
6. With MATRIX_WIN_LEN_CHECK_EN, a line 1 DE run of 7 → err_len = 1 at the DE fall; enables stay 0; err_len clears at the next vs_rise.
